// File: rtl/axis_nco_qw.sv
// axis_nco_qw: AXI-Stream NCO, phase accumulator into a quarter-wave sine ROM.
// Define AXIS_NCO_QW_DITHER_EN to add LFSR phase dither ahead of the ROM address.
module axis_nco_qw #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter bit SIGNED_OUT = 1'b0
) (
  input  logic                  aclk,
  input  logic                  arst,
  input  logic [ACC_WIDTH-1:0]  phase_offset,
  input  logic                  phase_sync,
  input  logic [ACC_WIDTH-1:0]  s_axis_freq_tdata,
  input  logic                  s_axis_freq_tvalid,
  output logic                  s_axis_freq_tready,
  output logic [DATA_WIDTH-1:0] m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready
);

  localparam int  JW = ADDR_WIDTH - 2;
  localparam int  M  = 1 << JW;
  localparam real PI = 3.14159265358979323846;
  localparam logic [DATA_WIDTH-1:0] OFS =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  if (ACC_WIDTH - ADDR_WIDTH > 32 || ADDR_WIDTH < 3 ||
      ADDR_WIDTH > ACC_WIDTH) begin : g_bad_cfg
    $error("axis_nco_qw: unsupported width configuration");
  end

  // Taylor series is exact to far below 1 LSB on [0, pi/2]
  function automatic real sin_r(input real x);
    real t;
    real s;
    t = x;
    s = x;
    for (int i = 1; i <= 12; i++) begin
      t = -t * x * x / real'((2 * i) * (2 * i + 1));
      s = s + t;
    end
    return s;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] q_entry(input int k);
    real x;
    real amp;
    x   = 2.0 * PI * (real'(k) + 0.5) / real'(M * 4);
    amp = real'(longint'(1) << (DATA_WIDTH - 1)) - 1.0;
    return DATA_WIDTH'($rtoi(amp * sin_r(x) + 0.5));
  endfunction

  logic [DATA_WIDTH-1:0] lut_w [M];

  for (genvar k = 0; k < M; k++) begin : g_lut
    localparam logic [DATA_WIDTH-1:0] QV = q_entry(k);
    assign lut_w[k] = QV;
  end

  logic                  adv;
  logic                  restart;
  logic                  tready_q;
  logic                  sync_pend_q;
  logic [ACC_WIDTH-1:0]  freq_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  p1_q, p1_d;
  logic [ACC_WIDTH-1:0]  dither;
  logic                  v1_q, v2_q, tvalid_q;
  logic [ADDR_WIDTH-1:0] a2;
  logic [1:0]            q2;
  logic [JW-1:0]         j2, idx2;
  logic [DATA_WIDTH-1:0] r2_q;
  logic                  neg2_q;
  logic [DATA_WIDTH-1:0] s3;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  unused_p1;

  assign adv     = ~tvalid_q | m_axis_data_tready;
  assign restart = sync_pend_q | phase_sync;

`ifdef AXIS_NCO_QW_DITHER_EN
  localparam int DW = ACC_WIDTH - ADDR_WIDTH;
  localparam logic [63:0] DMASK = (64'd1 << DW) - 64'd1;

  logic [31:0] lfsr_q, lfsr_d;

  // x^32 + x^22 + x^2 + x + 1
  assign lfsr_d = restart ? 32'h1 :
    {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  assign dither = ACC_WIDTH'({32'd0, lfsr_q} & DMASK);

  always_ff @(posedge aclk) begin
    if (arst) begin
      lfsr_q <= 32'h1;
    end else if (adv) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign dither = '0;
`endif

  assign acc_d = restart ? '0 : acc_q + freq_q;
  assign p1_d  = acc_q + phase_offset + dither;

  assign a2   = p1_q[ACC_WIDTH-1 -: ADDR_WIDTH];
  assign q2   = a2[ADDR_WIDTH-1 -: 2];
  assign j2   = a2[JW-1:0];
  assign idx2 = q2[0] ? ~j2 : j2;

  assign s3      = neg2_q ? -r2_q : r2_q;
  assign tdata_d = SIGNED_OUT ? s3 : s3 + OFS;

  assign unused_p1 = ^p1_q;

  always_ff @(posedge aclk) begin
    if (arst) begin
      tready_q    <= 1'b0;
      freq_q      <= '0;
      sync_pend_q <= 1'b0;
    end else begin
      tready_q <= 1'b1;
      if (s_axis_freq_tvalid && tready_q) begin
        freq_q <= s_axis_freq_tdata;
      end
      if (adv) begin
        sync_pend_q <= 1'b0;
      end else if (phase_sync) begin
        sync_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      acc_q    <= '0;
      p1_q     <= '0;
      v1_q     <= 1'b0;
      r2_q     <= '0;
      neg2_q   <= 1'b0;
      v2_q     <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else if (adv) begin
      acc_q    <= acc_d;
      p1_q     <= p1_d;
      v1_q     <= 1'b1;
      r2_q     <= lut_w[idx2];
      neg2_q   <= q2[1];
      v2_q     <= v1_q;
      tdata_q  <= tdata_d;
      tvalid_q <= v2_q;
    end
  end

  assign s_axis_freq_tready = tready_q;
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_nco_qw.sv
// tb_axis_nco_qw: directed checks of axis_nco_qw, offset-binary and
// signed instances, default build (no dither).
module tb_axis_nco_qw;

  logic        clk = 1'b0;
  logic        arst;
  logic [31:0] offset;
  logic        sync;
  logic [31:0] f_tdata;
  logic        f_tvalid;
  logic        f_tready;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;

  logic [31:0] offset2;
  logic        sync2;
  logic [31:0] f2_tdata;
  logic        f2_tvalid;
  logic        f2_tready;
  logic [15:0] tdata2;
  logic        tvalid2;
  logic        tready2;

  always #5 clk = ~clk;

  axis_nco_qw #(
    .ACC_WIDTH(32), .ADDR_WIDTH(10), .DATA_WIDTH(16), .SIGNED_OUT(1'b0)
  ) dut (
    .aclk(clk), .arst(arst),
    .phase_offset(offset), .phase_sync(sync),
    .s_axis_freq_tdata(f_tdata), .s_axis_freq_tvalid(f_tvalid),
    .s_axis_freq_tready(f_tready),
    .m_axis_data_tdata(tdata), .m_axis_data_tvalid(tvalid),
    .m_axis_data_tready(tready)
  );

  axis_nco_qw #(
    .ACC_WIDTH(32), .ADDR_WIDTH(10), .DATA_WIDTH(16), .SIGNED_OUT(1'b1)
  ) dut_s (
    .aclk(clk), .arst(arst),
    .phase_offset(offset2), .phase_sync(sync2),
    .s_axis_freq_tdata(f2_tdata), .s_axis_freq_tvalid(f2_tvalid),
    .s_axis_freq_tready(f2_tready),
    .m_axis_data_tdata(tdata2), .m_axis_data_tvalid(tvalid2),
    .m_axis_data_tready(tready2)
  );

  int errs = 0;
  int checks = 0;

  typedef struct {
    int          idx;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [11];
  logic [15:0] cap [0:1099];
  int          ncap;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  // Independent full-wave reference, offset binary
  function automatic logic [15:0] ref_s(input int idx);
    real x;
    int  v;
    x = 32767.0 * $sin(2.0 * 3.14159265358979 *
                       (real'(idx % 1024) + 0.5) / 1024.0);
    v = $rtoi($floor(x + 0.5));
    return 16'(v + 32768);
  endfunction

  // Restart phase with a sync pulse, then collect accepted samples
  // from index 0, optionally stalling the sink at sample st_at.
  task automatic stream(input int n, input int st_at, input int st_len);
    int          skip;
    int          stall;
    int          cyc;
    logic [15:0] hold;
    skip  = 0;
    stall = 0;
    cyc   = 0;
    hold  = '0;
    ncap  = 0;
    @(negedge clk);
    sync   = 1'b1;
    tready = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    while (ncap < n && cyc < 4000) begin
      if (skip < 3) begin
        skip++;
      end else if (ncap == st_at && stall < st_len) begin
        if (stall == 0) begin
          hold = tdata;
        end else begin
          chk("stall_hold", 32'(tdata), 32'(hold));
          chk("stall_valid", 32'(tvalid), 32'd1);
        end
        tready = 1'b0;
        stall++;
      end else begin
        tready = 1'b1;
        if (tvalid) begin
          cap[ncap] = tdata;
          ncap++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    tready = 1'b1;
    chk("stream_count", 32'(ncap), 32'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold;
    logic [15:0] exp2 [6];

    tbl[0]  = '{0,    16'd32869};
    tbl[1]  = '{1,    16'd33070};
    tbl[2]  = '{2,    16'd33271};
    tbl[3]  = '{255,  16'd65535};
    tbl[4]  = '{256,  16'd65535};
    tbl[5]  = '{511,  16'd32869};
    tbl[6]  = '{512,  16'd32667};
    tbl[7]  = '{767,  16'd1};
    tbl[8]  = '{768,  16'd1};
    tbl[9]  = '{1023, 16'd32667};
    tbl[10] = '{1024, 16'd32869};

    exp2[0] = 16'h0065;
    exp2[1] = 16'h0065;
    exp2[2] = 16'h0065;
    exp2[3] = 16'hFF9B;
    exp2[4] = 16'h0065;
    exp2[5] = 16'hFF9B;

    arst      = 1'b1;
    offset    = '0;
    sync      = 1'b0;
    f_tdata   = '0;
    f_tvalid  = 1'b0;
    tready    = 1'b1;
    offset2   = '0;
    sync2     = 1'b0;
    f2_tdata  = 32'h8000_0000;
    f2_tvalid = 1'b1;
    tready2   = 1'b1;

    // Reset state, then latency and constant output at freq 0
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_ftready", 32'(f_tready), 32'd0);
    arst = 1'b0;
    @(negedge clk);
    chk("e1_tvalid", 32'(tvalid), 32'd0);
    chk("e1_ftready", 32'(f_tready), 32'd1);
    @(negedge clk);
    chk("e2_tvalid", 32'(tvalid), 32'd0);
    for (int e = 0; e < 6; e++) begin
      @(negedge clk);
      chk("const_tvalid", 32'(tvalid), 32'd1);
      chk("const_tdata", 32'(tdata), 32'd32869);
      chk("signed_tdata", 32'(tdata2), 32'(exp2[e]));
    end

    // Address ramp of +1 per sample, full wrap
    @(negedge clk);
    f_tdata  = 32'h0040_0000;
    f_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    stream(1030, -1, 0);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tbl_idx%0d", tbl[i].idx),
          32'(cap[tbl[i].idx]), 32'(tbl[i].exp));
    end
    for (int k = 0; k < 1030; k++) begin
      chk($sformatf("ramp_idx%0d", k), 32'(cap[k]), 32'(ref_s(k)));
    end

    // Backpressure mid-stream keeps the sequence contiguous
    stream(40, 17, 5);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("bp_idx%0d", k), 32'(cap[k]), 32'(ref_s(k)));
    end

    // Sync arriving during a stall is held until the next advance
    @(negedge clk);
    offset = 32'h4000_0000;
    tready = 1'b0;
    @(negedge clk);
    hold = tdata;
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_stall_hold", 32'(tdata), 32'(hold));
    @(negedge clk);
    chk("sync_stall_hold2", 32'(tdata), 32'(hold));
    chk("sync_stall_valid", 32'(tvalid), 32'd1);
    tready = 1'b1;
    repeat (4) @(negedge clk);
    chk("sync_idx256", 32'(tdata), 32'd65535);
    @(negedge clk);
    chk("sync_idx257", 32'(tdata), 32'(ref_s(257)));

    // Reset pulse while streaming, then deterministic restart
    offset = '0;
    @(negedge clk);
    chk("pre_rst_tvalid", 32'(tvalid), 32'd1);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    chk("rst6_tvalid", 32'(tvalid), 32'd0);
    chk("rst6_ftready", 32'(f_tready), 32'd0);
    chk("rst6_tdata", 32'(tdata), 32'd0);
    @(negedge clk);
    chk("rst6_e1_tvalid", 32'(tvalid), 32'd0);
    chk("rst6_e1_ftready", 32'(f_tready), 32'd1);
    @(negedge clk);
    chk("rst6_e2_tvalid", 32'(tvalid), 32'd0);
    for (int m = 0; m < 21; m++) begin
      @(negedge clk);
      chk($sformatf("rst6_tvalid_%0d", m), 32'(tvalid), 32'd1);
      chk($sformatf("rst6_seq_%0d", m), 32'(tdata),
          32'(ref_s(m < 3 ? 0 : m - 2)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
